// File: rtl/div_pkg.sv
// Shared definitions for the DIVU restoring-division sequencer.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/rpas32.sv
// RPAS32: 32-bit ripple add/subtract; with sub=1 it computes a-b and cout=1 means a>=b.
module RPAS32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] sum,
  output logic        cout
);

  always_comb begin
    logic carry;
    logic bx;
    carry = sub;
    sum   = '0;
    for (int i = 0; i < 32; i++) begin
      bx     = b[i] ^ sub;
      sum[i] = a[i] ^ bx ^ carry;
      carry  = (a[i] & bx) | (carry & (a[i] ^ bx));
    end
    cout = carry;
  end

endmodule

// File: rtl/div_sequencer.sv
// Unsigned restoring-division controller; drives a shared external subtractor
// and returns quotient/remainder through a start/busy/done handshake.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_diff,
  input  logic             sub_c
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] trial;
  logic             accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // rem_q[WIDTH-1] stands in for the bit shifted out of trial, so the trial
  // value exceeds any divisor whenever it is set.
  assign trial  = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign accept = rem_q[WIDTH-1] | sub_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    sub_a       = '0;
    sub_b       = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvsr_d = divisor;
          dbz_d  = (divisor == '0);
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            state_d     = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = dividend;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        sub_a = trial;
        sub_b = dvsr_q;
        rem_d = accept ? sub_diff : trial;
        quo_d = {quo_q[WIDTH-2:0], accept};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quotient_d  = quo_d;
          remainder_d = rem_d;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer wired to an RPAS32 subtractor.
module tb_div_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic [31:0] sub_a;
  logic [31:0] sub_b;
  logic [31:0] sub_diff;
  logic        sub_c;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int lat;

  div_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .sub_a       (sub_a),
    .sub_b       (sub_b),
    .sub_diff    (sub_diff),
    .sub_c       (sub_c)
  );

  RPAS32 u_sub (
    .a    (sub_a),
    .b    (sub_b),
    .sub  (1'b1),
    .sum  (sub_diff),
    .cout (sub_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Present operands with start for one accepting edge; returns #1 after that edge.
  task automatic applyStimulus(input logic [31:0] dvnd, input logic [31:0] dvsr);
    dividend = dvnd;
    divisor  = dvsr;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 1;
    while (!done && cycles < 60) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] dvnd, input logic [31:0] dvsr,
                       input logic [31:0] exp_q, input logic [31:0] exp_r);
    int cycles;
    applyStimulus(dvnd, dvsr);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    waitDone(cycles);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'd33);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_quotient"}, quotient, exp_q);
    checkOutput({tag, "_remainder"}, remainder, exp_r);
    checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_idle_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_quotient", quotient, 32'd0);
    checkOutput("rst_remainder", remainder, 32'd0);
    checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 100/7 with a look at the subtractor operands on the first RUN cycle.
    applyStimulus(32'd100, 32'd7);
    checkOutput("b100_busy", 32'(busy), 32'd1);
    checkOutput("b100_sub_b", sub_b, 32'd7);
    checkOutput("b100_sub_a", sub_a, 32'd0);
    waitDone(lat);
    checkOutput("b100_latency", 32'(lat), 32'd33);
    checkOutput("b100_quotient", quotient, 32'd14);
    checkOutput("b100_remainder", remainder, 32'd2);
    checkOutput("b100_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("b100_idle_done", 32'(done), 32'd0);
    checkOutput("b100_hold_q", quotient, 32'd14);

    runOp("rmsb", 32'hFFFF_FFFE, 32'h8000_0001, 32'd1, 32'h7FFF_FFFD);
    runOp("small", 32'd3, 32'd5, 32'd0, 32'd3);
    runOp("by_one", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);

    // Divide by zero finishes on the next cycle and never touches the subtractor.
    checkOutput("dz_pre_sub_a", sub_a, 32'd0);
    applyStimulus(32'd5, 32'd0);
    checkOutput("dz_done", 32'(done), 32'd1);
    checkOutput("dz_quotient", quotient, 32'hFFFF_FFFF);
    checkOutput("dz_remainder", remainder, 32'd5);
    checkOutput("dz_flag", 32'(div_by_zero), 32'd1);
    checkOutput("dz_sub_a", sub_a, 32'd0);
    checkOutput("dz_sub_b", sub_b, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("dz_idle_busy", 32'(busy), 32'd0);
    checkOutput("dz_hold_flag", 32'(div_by_zero), 32'd1);

    // A busy-time start is ignored; a start held through DONE is taken in IDLE.
    applyStimulus(32'd100, 32'd7);
    checkOutput("ign_dbz_clear", 32'(div_by_zero), 32'd0);
    lat = 1;
    while (!done && lat < 60) begin
      if (lat == 10) begin
        dividend = 32'd9;
        divisor  = 32'd2;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    dividend = 32'd9;
    divisor  = 32'd2;
    start    = 1'b1;
    checkOutput("ign_latency", 32'(lat), 32'd33);
    checkOutput("ign_quotient", quotient, 32'd14);
    checkOutput("ign_remainder", remainder, 32'd2);
    @(posedge clk);
    #1;
    checkOutput("held_idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("held_accept_busy", 32'(busy), 32'd1);
    waitDone(lat);
    checkOutput("held_latency", 32'(lat), 32'd33);
    checkOutput("held_quotient", quotient, 32'd4);
    checkOutput("held_remainder", remainder, 32'd1);
    @(posedge clk);
    #1;

    // Mid-operation reset clears everything without waiting for a clock edge.
    applyStimulus(32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    checkOutput("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_quotient", quotient, 32'd0);
    checkOutput("abort_remainder", remainder, 32'd0);
    checkOutput("abort_sub_a", sub_a, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    runOp("post_abort", 32'd9, 32'd2, 32'd4, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multi-cycle unsigned restoring-division controller for the MIPS core's DIVU path.
- Owns the partial remainder, quotient and iteration counter.
- Sequences an external shared add/subtract unit through its sub_* ports. That unit is the team's RPAS32 32-bit ripple add/subtract, instantiated by the parent.
- Produces quotient and remainder with a start/busy/done handshake. Sits beside the ALU and feeds HI/LO.

Parameters:
WIDTH, 32, operand/result width; must match the external subtractor width.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
clk  input  1  system clock, rising-edge active.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
dividend  input  WIDTH  numerator; captured on an accepted start.
divisor  input  WIDTH  denominator; captured on an accepted start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; results are valid from this cycle.
quotient  output  WIDTH  registered quotient.
remainder  output  WIDTH  registered remainder.
div_by_zero  output  1  registered; set when the captured divisor is 0.
sub_a  output  WIDTH  minuend to the shared subtractor.
sub_b  output  WIDTH  subtrahend to the shared subtractor.
sub_diff  input  WIDTH  sub_a - sub_b (mod 2^WIDTH).
sub_c  input  1  carry out; 1 means sub_a >= sub_b, unsigned (no borrow).

Behaviour:
- One clock domain (clk); reset is asynchronous, active-high.
- While reset is high: state=IDLE; counter=0; quotient, remainder, busy, done and div_by_zero all 0. Reset mid-operation aborts the operation and discards all partial results.
- States and transitions:
  - IDLE: on start=1, capture the operands and clear div_by_zero. If divisor==0, go to DONE. Otherwise go to RUN with R=0, Q=dividend, counter=0.
  - RUN: one quotient bit per cycle, for exactly WIDTH cycles. Go to DONE when counter==WIDTH-1 completes.
  - DONE: done=1 for exactly one cycle, then return to IDLE unconditionally.
- RUN iteration, with every signal combinational from the registers:
  - trial = {R[WIDTH-2:0], Q[WIDTH-1]}; rmsb = R[WIDTH-1].
  - sub_a = trial; sub_b = divisor register.
  - accept = rmsb | sub_c. The rmsb term covers the implicit WIDTH+1-th bit when the divisor MSB is set.
  - Next R = accept ? sub_diff : trial. Next Q = {Q[WIDTH-2:0], accept}. Counter increments.
- Outside RUN, sub_a and sub_b are driven to 0, so the parent may share the subtractor in those cycles.
- On entry to DONE:
  - Normal operation: quotient=Q, remainder=R.
  - divisor==0: quotient = all ones, remainder = dividend, div_by_zero=1.
- Latency from the accepted start edge to done high:
  - normal operation: WIDTH+1 cycles (33 at the default width);
  - divisor==0: 1 cycle.
- quotient, remainder and div_by_zero hold their values until the next accepted start. A new start clears div_by_zero only; quotient and remainder are updated on entry to DONE.
- start while busy is ignored: no restart, no queuing.
- start in the same cycle done is high is also ignored, because the FSM is still in DONE.
- A start held continuously is accepted again on the first IDLE cycle.
- No combinational path from start to busy or done; all handshake outputs are registered or decoded from the state register.

Decomposition:
- Package div_pkg holds:
  - the state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - a DIV_WIDTH default constant of 32.
- Single module; no sub-module is needed.
- The subtractor stays outside the block so that the ALU can share it in non-RUN cycles.
- The testbench instantiates the block together with RPAS32 wired to the sub_* ports.

Test Plan:
- Reset, then dividend=100, divisor=7, start for 1 cycle -> busy=1; done pulses 33 cycles after start; quotient=14, remainder=2, div_by_zero=0.
- dividend=32'hFFFFFFFE, divisor=32'h80000001 (rmsb path) -> quotient=1, remainder=32'h7FFFFFFD.
- dividend=3, divisor=5 -> quotient=0, remainder=3. Then dividend=32'hFFFFFFFF, divisor=1 -> quotient=32'hFFFFFFFF, remainder=0.
- dividend=5, divisor=0 -> done 1 cycle after start; quotient=32'hFFFFFFFF, remainder=5, div_by_zero=1; sub_a and sub_b stay 0 throughout.
- Start 100/7, pulse start with 9/2 at cycle 10, and hold start high during the DONE cycle -> the first operation completes with 14/2. The held start is accepted in the next IDLE cycle.
- Start 100/7, assert reset at cycle 15 -> all outputs 0 immediately (asynchronously). After release, 9/2 completes with quotient=4, remainder=1 at the normal latency.
